// File: rtl/pes_graycode_updown_if.sv
// Control/status bundle for the up/down Gray-code counter.
// master drives the step/clear/load requests; slave is the counter itself.
interface pes_graycode_updown_if #(
    parameter int unsigned WIDTH = 8
);
    logic             enable;
    logic             up_down;
    logic             clear;
    logic             load;
    logic [WIDTH-1:0] load_value;
    logic [WIDTH-1:0] gray_count;
    logic [WIDTH-1:0] bin_count;
    logic             terminal;
    logic             wrap;

    modport master (
        output enable, up_down, clear, load, load_value,
        input  gray_count, bin_count, terminal, wrap
    );

    modport slave (
        input  enable, up_down, clear, load, load_value,
        output gray_count, bin_count, terminal, wrap
    );
endinterface

// File: rtl/pes_graycode_updown.sv
// Parametrised up/down Gray-code counter with clear, Gray load, wrap/saturate
// modes, binary shadow output and terminal/wrap indications.
module pes_graycode_updown #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned SATURATE = 0,
    parameter int unsigned INIT     = 0
) (
    input logic                  clk,
    input logic                  reset,
    pes_graycode_updown_if.slave bus
);
    typedef enum logic [1:0] {
        OP_HOLD,
        OP_CLEAR,
        OP_LOAD,
        OP_STEP
    } op_e;

    localparam logic [WIDTH-1:0] INIT_BIN  = WIDTH'(INIT);
    localparam logic [WIDTH-1:0] INIT_GRAY = INIT_BIN ^ (INIT_BIN >> 1);

    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] b_d;
    logic [WIDTH-1:0] g_q;
    logic [WIDTH-1:0] g_d;
    logic             wrap_q;
    logic             wrap_d;
    op_e              op;

    function automatic logic [WIDTH-1:0] gray_to_bin(input logic [WIDTH-1:0] g);
        logic [WIDTH-1:0] b;
        b = '0;
        b[WIDTH-1] = g[WIDTH-1];
        for (int unsigned k = 1; k < WIDTH; k++) begin
            b[WIDTH-1-k] = b[WIDTH-k] ^ g[WIDTH-1-k];
        end
        return b;
    endfunction

    always_comb begin
        op = OP_HOLD;
        if (bus.clear) begin
            op = OP_CLEAR;
        end else if (bus.load) begin
            op = OP_LOAD;
        end else if (bus.enable) begin
            op = OP_STEP;
        end
    end

    always_comb begin
        b_d    = b_q;
        wrap_d = 1'b0;
        case (op)
            OP_CLEAR: b_d = '0;
            OP_LOAD:  b_d = gray_to_bin(bus.load_value);
            OP_STEP: begin
                if (bus.up_down) begin
                    if (b_q == '1) begin
                        if (SATURATE == 0) begin
                            b_d    = '0;
                            wrap_d = 1'b1;
                        end
                    end else begin
                        b_d = b_q + WIDTH'(1);
                    end
                end else begin
                    if (b_q == '0) begin
                        if (SATURATE == 0) begin
                            b_d    = '1;
                            wrap_d = 1'b1;
                        end
                    end else begin
                        b_d = b_q - WIDTH'(1);
                    end
                end
            end
            default: ;
        endcase
    end

    // Gray output is registered from the next binary value so it never glitches.
    assign g_d = b_d ^ (b_d >> 1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            b_q    <= INIT_BIN;
            g_q    <= INIT_GRAY;
            wrap_q <= 1'b0;
        end else begin
            b_q    <= b_d;
            g_q    <= g_d;
            wrap_q <= wrap_d;
        end
    end

    assign bus.gray_count = g_q;
    assign bus.bin_count  = b_q;
    assign bus.wrap       = wrap_q;
    assign bus.terminal   = bus.up_down ? (b_q == '1) : (b_q == '0);

endmodule

// File: tb/tb_pes_graycode_updown.sv
// Scoreboard bench: three counters (4-bit wrap, 4-bit saturate, 8-bit wrap)
// share one control stream and are checked against an arithmetic model.
module tb_pes_graycode_updown;
    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    pes_graycode_updown_if #(.WIDTH(4)) ifa ();
    pes_graycode_updown_if #(.WIDTH(4)) ifb ();
    pes_graycode_updown_if #(.WIDTH(8)) ifc ();

    pes_graycode_updown #(.WIDTH(4), .SATURATE(0), .INIT(0)) dut_a (
        .clk(clk), .reset(reset), .bus(ifa));
    pes_graycode_updown #(.WIDTH(4), .SATURATE(1), .INIT(0)) dut_b (
        .clk(clk), .reset(reset), .bus(ifb));
    pes_graycode_updown #(.WIDTH(8), .SATURATE(0), .INIT(0)) dut_c (
        .clk(clk), .reset(reset), .bus(ifc));

    typedef struct {
        logic [3:0] ba;
        logic [3:0] bb;
        logic [7:0] bc;
        logic [2:0] wr;
        logic [2:0] tm;
        bit         onebit;
    } exp_t;

    exp_t        q[$];
    int unsigned vectors    = 0;
    int unsigned miscompares = 0;

    int unsigned mb[3];
    bit          mw[3];
    int unsigned mwidth[3] = '{4, 4, 8};
    bit          msat[3]   = '{1'b0, 1'b1, 1'b0};
    bit          last_step = 1'b0;

    function automatic int unsigned g2b(input int unsigned g, input int unsigned w);
        for (int unsigned v = 0; v < (32'd1 << w); v++) begin
            if ((v ^ (v >> 1)) == g) return v;
        end
        return 0;
    endfunction

    task automatic check(input string name, input int unsigned act, input int unsigned exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            mb[k] = 0;
            mw[k] = 1'b0;
        end
    endtask

    task automatic cycle(input bit rst, input bit en, input bit ud, input bit clr,
                         input bit ld, input logic [7:0] lv);
        exp_t        e;
        int unsigned mx;
        @(posedge clk);
        #1;
        reset = rst;
        ifa.enable = en; ifa.up_down = ud; ifa.clear = clr; ifa.load = ld; ifa.load_value = lv[3:0];
        ifb.enable = en; ifb.up_down = ud; ifb.clear = clr; ifb.load = ld; ifb.load_value = lv[3:0];
        ifc.enable = en; ifc.up_down = ud; ifc.clear = clr; ifc.load = ld; ifc.load_value = lv;
        if (!rst) model_reset();
        e.ba = 4'(mb[0]);
        e.bb = 4'(mb[1]);
        e.bc = 8'(mb[2]);
        for (int k = 0; k < 3; k++) begin
            mx = (32'd1 << mwidth[k]) - 1;
            e.wr[k] = mw[k];
            e.tm[k] = ud ? (mb[k] == mx) : (mb[k] == 0);
        end
        e.onebit = last_step;
        q.push_back(e);
        last_step = rst && en && !clr && !ld;
        if (rst) begin
            for (int k = 0; k < 3; k++) begin
                mx = (32'd1 << mwidth[k]) - 1;
                mw[k] = 1'b0;
                if (clr) begin
                    mb[k] = 0;
                end else if (ld) begin
                    mb[k] = g2b(int'(lv) & mx, mwidth[k]);
                end else if (en && ud) begin
                    if (mb[k] == mx) begin
                        if (!msat[k]) begin mb[k] = 0; mw[k] = 1'b1; end
                    end else mb[k] = mb[k] + 1;
                end else if (en) begin
                    if (mb[k] == 0) begin
                        if (!msat[k]) begin mb[k] = mx; mw[k] = 1'b1; end
                    end else mb[k] = mb[k] - 1;
                end
            end
        end
    endtask

    // Monitor: every cycle the registered outputs are presented; compare mid-cycle.
    logic [3:0] prev_ga = '0;
    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            check("gray_a", ifa.gray_count, e.ba ^ (e.ba >> 1));
            check("bin_a",  ifa.bin_count,  e.ba);
            check("wrap_a", ifa.wrap,       e.wr[0]);
            check("term_a", ifa.terminal,   e.tm[0]);
            check("gray_b", ifb.gray_count, e.bb ^ (e.bb >> 1));
            check("bin_b",  ifb.bin_count,  e.bb);
            check("wrap_b", ifb.wrap,       e.wr[1]);
            check("term_b", ifb.terminal,   e.tm[1]);
            check("gray_c", ifc.gray_count, e.bc ^ (e.bc >> 1));
            check("bin_c",  ifc.bin_count,  e.bc);
            check("wrap_c", ifc.wrap,       e.wr[2]);
            check("term_c", ifc.terminal,   e.tm[2]);
            if (e.onebit) check("onebit_a", $countones(ifa.gray_count ^ prev_ga), 1);
            prev_ga = ifa.gray_count;
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running, expected done");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b0;
        ifa.enable = 0; ifa.up_down = 0; ifa.clear = 0; ifa.load = 0; ifa.load_value = '0;
        ifb.enable = 0; ifb.up_down = 0; ifb.clear = 0; ifb.load = 0; ifb.load_value = '0;
        ifc.enable = 0; ifc.up_down = 0; ifc.clear = 0; ifc.load = 0; ifc.load_value = '0;
        model_reset();

        cycle(0, 0, 1, 0, 0, 8'h00);
        cycle(0, 1, 1, 0, 0, 8'h00);
        for (int i = 0; i < 5; i++) cycle(1, 1, 1, 0, 0, 8'h00);
        cycle(1, 0, 1, 0, 0, 8'h00);

        // Asynchronous reset between edges with the counter at 5
        @(negedge clk);
        #1;
        reset = 1'b0;
        #1;
        check("async_gray_a", ifa.gray_count, 0);
        check("async_bin_a",  ifa.bin_count,  0);
        check("async_wrap_a", ifa.wrap,       0);
        check("async_bin_c",  ifc.bin_count,  0);
        model_reset();
        last_step = 1'b0;
        cycle(0, 1, 1, 0, 0, 8'h00);
        cycle(0, 1, 1, 0, 0, 8'h00);

        for (int i = 0; i < 16; i++) cycle(1, 1, 1, 0, 0, 8'h00);
        cycle(1, 0, 1, 0, 0, 8'h00);
        cycle(1, 0, 0, 1, 0, 8'h00);
        cycle(1, 1, 0, 0, 0, 8'h00);
        cycle(1, 0, 0, 0, 0, 8'h00);
        cycle(1, 0, 1, 0, 1, 8'h0D);
        cycle(1, 0, 1, 0, 0, 8'h00);
        cycle(1, 1, 1, 1, 1, 8'hA5);
        cycle(1, 0, 1, 0, 0, 8'h00);
        for (int i = 0; i < 18; i++) cycle(1, 1, 1, 0, 0, 8'h00);
        cycle(1, 1, 0, 0, 0, 8'h00);
        cycle(1, 0, 1, 1, 0, 8'h00);
        for (int i = 0; i < 256; i++) cycle(1, 1, 1, 0, 0, 8'h00);
        cycle(1, 0, 1, 0, 0, 8'h00);

        for (int i = 0; i < 300; i++) begin
            cycle(1, $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                  $urandom_range(0, 15) == 0, $urandom_range(0, 15) == 0, 8'($urandom));
        end
        cycle(1, 0, 1, 0, 0, 8'h00);

        @(negedge clk);
        @(negedge clk);
        #1;
        check("queue_drained", q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
